// File: rtl/mem_bus_master.sv
// mem_bus_master: turns decoder write/read strobes into single-word req/ack bus
// transactions, keeps a word-address pointer with optional post-increment,
// returns read data as a one-cycle strobe and flags timeouts / dropped commands.
module mem_bus_master #(
    parameter int          AW       = 16,
    parameter int          TIMEOUT  = 255,
    parameter int unsigned AUTO_INC = 1
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_addr_load,
    input  logic [31:0]   i_addr,
    input  logic          i_wr_cmd,
    input  logic          i_rd_cmd,
    input  logic [31:0]   i_wdata,
    input  logic          i_err_clr,
    output logic          o_busy,
    output logic          o_rd_valid,
    output logic [31:0]   o_rdata,
    output logic [1:0]    o_err,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    input  logic          i_mem_ack,
    input  logic [31:0]   i_mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          state_q,    state_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic [AW-1:0]   ptr_q,      ptr_d;
    logic            we_q,       we_d;
    logic [AW-1:0]   addr_q,     addr_d;
    logic [31:0]     wdata_q,    wdata_d;
    logic [31:0]     rdata_q,    rdata_d;
    logic            rd_valid_q, rd_valid_d;
    logic [1:0]      err_q,      err_d;
    logic [1:0]      err_set;
    logic            cmd;

    // Only the low AW bits of the address register form the pointer.
    logic unused_addr;
    assign unused_addr = ^i_addr;

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Next-state: command acceptance, ack/timeout handling, pointer and error updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        err_set    = '0;
        cmd        = i_wr_cmd | i_rd_cmd;

        unique case (state_q)
            S_IDLE: begin
                if (cmd) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    we_d    = i_wr_cmd;
                    addr_d  = i_addr_load ? i_addr[AW-1:0] : ptr_q;
                    wdata_d = i_wdata;
                    if (i_wr_cmd && i_rd_cmd) begin
                        err_set[1] = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cmd) begin
                    err_set[1] = 1'b1;
                end
                if (i_mem_ack) begin
                    state_d = S_IDLE;
                    ptr_d   = ptr_q + AW'(AUTO_INC);
                    if (!we_q) begin
                        rdata_d    = i_mem_rdata;
                        rd_valid_d = 1'b1;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d    = S_IDLE;
                    err_set[0] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A load coinciding with completion takes precedence over the increment.
        if (i_addr_load) begin
            ptr_d = i_addr[AW-1:0];
        end

        err_d = (i_err_clr ? 2'b00 : err_q) | err_set;
    end

    assign o_busy      = (state_q == S_WAIT);
    assign o_mem_req   = (state_q == S_WAIT);
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_rdata     = rdata_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: two instances (AUTO_INC=1 and AUTO_INC=0) share the
// stimulus; a transaction-level model predicts all outputs every cycle, and
// directed scenarios add literal expectations.
module tb_mem_bus_master;

    localparam int TO = 4;

    logic        clk, nrst;
    logic        addr_load, wr, rd, err_clr, ack;
    logic [31:0] addr, wdata, mrdata;

    logic        busy1, rdv1, req1, we1;
    logic [31:0] rdata1, wdata1;
    logic [1:0]  err1;
    logic [15:0] maddr1;

    logic        busy0, rdv0, req0, we0;
    logic [31:0] rdata0, wdata0;
    logic [1:0]  err0;
    logic [15:0] maddr0;

    mem_bus_master #(.AW(16), .TIMEOUT(TO), .AUTO_INC(1)) u_dut (
        .i_clk(clk), .i_nrst(nrst), .i_addr_load(addr_load), .i_addr(addr),
        .i_wr_cmd(wr), .i_rd_cmd(rd), .i_wdata(wdata), .i_err_clr(err_clr),
        .o_busy(busy1), .o_rd_valid(rdv1), .o_rdata(rdata1), .o_err(err1),
        .o_mem_req(req1), .o_mem_we(we1), .o_mem_addr(maddr1), .o_mem_wdata(wdata1),
        .i_mem_ack(ack), .i_mem_rdata(mrdata)
    );

    mem_bus_master #(.AW(16), .TIMEOUT(TO), .AUTO_INC(0)) u_dut_noinc (
        .i_clk(clk), .i_nrst(nrst), .i_addr_load(addr_load), .i_addr(addr),
        .i_wr_cmd(wr), .i_rd_cmd(rd), .i_wdata(wdata), .i_err_clr(err_clr),
        .o_busy(busy0), .o_rd_valid(rdv0), .o_rdata(rdata0), .o_err(err0),
        .o_mem_req(req0), .o_mem_we(we0), .o_mem_addr(maddr0), .o_mem_wdata(wdata0),
        .i_mem_ack(ack), .i_mem_rdata(mrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Index k: k=1 models the incrementing instance, k=0 the holding one.
    logic        m_busy, m_we, m_rdv;
    logic [31:0] m_wdata, m_rdata;
    logic [1:0]  m_err, m_newerr;
    logic [15:0] m_ptr  [2];
    logic [15:0] m_addr [2];
    int          m_waited;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_busy = 0; m_we = 0; m_rdv = 0; m_wdata = 0; m_rdata = 0;
            m_err = 0; m_waited = 0;
            for (int k = 0; k < 2; k++) begin
                m_ptr[k] = 0; m_addr[k] = 0;
            end
        end else begin
            m_newerr = 2'b00;
            m_rdv    = 0;
            if (!m_busy) begin
                if (wr || rd) begin
                    m_busy = 1; m_we = wr; m_wdata = wdata; m_waited = 0;
                    for (int k = 0; k < 2; k++)
                        m_addr[k] = addr_load ? addr[15:0] : m_ptr[k];
                    if (wr && rd) m_newerr[1] = 1'b1;
                end
            end else begin
                m_waited++;
                if (wr || rd) m_newerr[1] = 1'b1;
                if (ack) begin
                    m_busy = 0;
                    if (!m_we) begin
                        m_rdata = mrdata; m_rdv = 1;
                    end
                    for (int k = 0; k < 2; k++) m_ptr[k] = m_ptr[k] + 16'(k);
                end else if (m_waited == TO) begin
                    m_busy = 0;
                    m_newerr[0] = 1'b1;
                end
            end
            if (addr_load)
                for (int k = 0; k < 2; k++) m_ptr[k] = addr[15:0];
            m_err = (err_clr ? 2'b00 : m_err) | m_newerr;
        end
    end

    // ---------------- per-cycle compare + activity counters ----------------
    int busy_cnt = 0;
    int rdv_cnt  = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (busy1) busy_cnt++;
            if (rdv1)  rdv_cnt++;
            chk("busy",      busy1,  m_busy);
            chk("mem_req",   req1,   m_busy);
            chk("rd_valid",  rdv1,   m_rdv);
            chk("rdata",     rdata1, m_rdata);
            chk("err",       err1,   m_err);
            chk("noinc_busy", busy0, m_busy);
            chk("noinc_err",  err0,  m_err);
            if (m_busy) begin
                chk("mem_we",     we1,    m_we);
                chk("mem_wdata",  wdata1, m_wdata);
                chk("mem_addr",   maddr1, m_addr[1]);
                chk("noinc_addr", maddr0, m_addr[0]);
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic cmd(input bit w, input bit r, input bit ld, input logic [31:0] a,
                       input logic [31:0] d, input bit clr);
        wr = w; rd = r; addr_load = ld; addr = a; wdata = d; err_clr = clr;
        @(negedge clk);
        wr = 0; rd = 0; addr_load = 0; err_clr = 0;
    endtask

    task automatic ack_after(input int n, input logic [31:0] d);
        repeat (n) @(negedge clk);
        ack = 1; mrdata = d;
        @(negedge clk);
        ack = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 0; addr_load = 0; wr = 0; rd = 0; err_clr = 0; ack = 0;
        addr = 0; wdata = 0; mrdata = 0;
        #3;
        chk("rst_busy",  busy1,  1'b0);
        chk("rst_req",   req1,   1'b0);
        chk("rst_err",   err1,   2'b00);
        chk("rst_rdv",   rdv1,   1'b0);
        chk("rst_addr",  maddr1, 16'h0000);
        chk("rst_rdata", rdata1, 32'h0);
        @(negedge clk); @(negedge clk);
        nrst = 1;
        @(negedge clk);

        // 1: load + write, ack on the TIMEOUT-th wait cycle still succeeds
        busy_cnt = 0;
        cmd(1, 0, 1, 32'hABCD_0010, 32'hDEAD_BEEF, 0);
        chk("t1_we",    we1,    1'b1);
        chk("t1_addr",  maddr1, 16'h0010);
        chk("t1_wdata", wdata1, 32'hDEAD_BEEF);
        ack_after(3, 32'h0);
        chk("t1_req_cycles", busy_cnt, 4);
        chk("t1_err", err1, 2'b00);

        // 2: read from incremented pointer, ack after one cycle
        busy_cnt = 0; rdv_cnt = 0;
        cmd(0, 1, 0, 32'h0, 32'h0, 0);
        chk("t2_addr",   maddr1, 16'h0011);
        chk("t2_noinc",  maddr0, 16'h0010);
        chk("t2_we",     we1,    1'b0);
        ack_after(1, 32'hCAFE_F00D);
        @(negedge clk);
        chk("t2_rdata",  rdata1, 32'hCAFE_F00D);
        chk("t2_busy_cycles", busy_cnt, 2);
        chk("t2_rdv_pulses",  rdv_cnt,  1);

        // 3: no ack -> timeout after exactly TO request cycles
        busy_cnt = 0; rdv_cnt = 0;
        cmd(0, 1, 0, 32'h0, 32'h0, 0);
        chk("t3_addr", maddr1, 16'h0012);
        repeat (6) @(negedge clk);
        chk("t3_req_cycles", busy_cnt, 4);
        chk("t3_err",        err1,     2'b01);
        chk("t3_no_rdv",     rdv_cnt,  0);

        // 4: simultaneous wr+rd with a clear: write taken, clear loses to new error
        cmd(1, 1, 0, 32'h0, 32'h1234_5678, 1);
        chk("t4_addr", maddr1, 16'h0012);
        chk("t4_we",   we1,    1'b1);
        chk("t4_err",  err1,   2'b10);
        // read during WAIT is dropped; pointer reloads but bus address holds
        cmd(0, 1, 1, 32'h0000_0100, 32'h0, 0);
        chk("t4_addr_frozen", maddr1, 16'h0012);
        ack_after(1, 32'h0);
        chk("t4_err_hold", err1, 2'b10);
        cmd(0, 0, 0, 32'h0, 32'h0, 1);
        chk("t4_err_clr", err1, 2'b00);
        // stray ack while idle
        ack_after(0, 32'h5555_AAAA);
        cmd(0, 1, 0, 32'h0, 32'h0, 0);
        chk("t4_ptr_inc",   maddr1, 16'h0101);
        chk("t4_ptr_noinc", maddr0, 16'h0100);
        ack_after(0, 32'h0BAD_F00D);

        // 5: pointer wrap, back-to-back accesses
        cmd(0, 1, 1, 32'h0000_FFFF, 32'h0, 0);
        chk("t5_addr", maddr1, 16'hFFFF);
        ack_after(0, 32'h1111_2222);
        busy_cnt = 0;
        cmd(0, 1, 0, 32'h0, 32'h0, 0);
        chk("t5_wrap",  maddr1, 16'h0000);
        chk("t5_hold",  maddr0, 16'hFFFF);
        ack_after(0, 32'h3333_4444);
        cmd(1, 0, 0, 32'h0, 32'h7777_8888, 0);
        chk("t5_b2b_addr", maddr1, 16'h0001);
        ack_after(0, 32'h0);
        chk("t5_b2b_busy", busy_cnt, 2);

        // 6: async reset mid-transaction, then a late ack
        cmd(1, 1, 0, 32'h0, 32'h9999_0000, 0);
        @(negedge clk);
        #2 nrst = 0;
        #1;
        chk("t6_req",  req1,  1'b0);
        chk("t6_busy", busy1, 1'b0);
        chk("t6_err",  err1,  2'b00);
        chk("t6_rdv",  rdv1,  1'b0);
        @(negedge clk);
        ack = 1; mrdata = 32'hFFFF_FFFF;
        @(negedge clk);
        nrst = 1;
        @(negedge clk);
        ack = 0;
        @(negedge clk);
        chk("t6_after_busy",  busy1,  1'b0);
        chk("t6_after_rdata", rdata1, 32'h0);
        cmd(0, 1, 0, 32'h0, 32'h0, 0);
        chk("t6_ptr_reset", maddr1, 16'h0000);
        ack_after(0, 32'h0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
